// File: rtl/sedff_pipe_bank.sv
// Bank of scan-enable D flip-flops, WIDTH bits by STAGES deep, with valid tracking
// and a saturating violation counter standing in for the per-cell notifier.
module sedff_pipe_bank #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             valid_in,
    input  logic             clr,
    input  logic             set,
    input  logic             se,
    input  logic             si,
    input  logic             notifier,
    output logic [WIDTH-1:0] q,
    output logic             valid_out,
    output logic             so,
    output logic [CNT_W-1:0] viol_cnt
);

    localparam int N = STAGES * WIDTH;

    // Stage s occupies chain bits [s*WIDTH +: WIDTH]; scan and pipeline share it.
    logic [N-1:0]      r_chain;
    logic [STAGES-1:0] r_vld;
    logic [CNT_W-1:0]  r_viol_cnt;

    logic [N-1:0]      w_chain_scan;
    logic [N-1:0]      w_chain_adv;
    logic [STAGES-1:0] w_vld_adv;
    logic              w_viol;
    logic              w_cnt_sat;

    always_comb begin
        w_chain_scan    = '0;
        w_chain_scan[0] = si;
        for (int k = 1; k < N; k++) begin
            w_chain_scan[k] = r_chain[k-1];
        end
    end

    always_comb begin
        w_chain_adv              = '0;
        w_chain_adv[WIDTH-1:0]   = d;
        for (int k = WIDTH; k < N; k++) begin
            w_chain_adv[k] = r_chain[k-WIDTH];
        end
        w_vld_adv    = '0;
        w_vld_adv[0] = valid_in;
        for (int s = 1; s < STAGES; s++) begin
            w_vld_adv[s] = r_vld[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
            r_vld   <= '0;
        end else if (clr) begin
            r_chain <= '0;
            r_vld   <= '0;
        end else if (set) begin
            r_chain <= '1;
            r_vld   <= '1;
        end else if (se) begin
            r_chain <= w_chain_scan;
        end else if (en) begin
            r_chain <= w_chain_adv;
            r_vld   <= w_vld_adv;
        end
    end

    // Counter runs independently of the data priority; clr/set never touch it.
    assign w_viol    = notifier | (clr & set);
    assign w_cnt_sat = &r_viol_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_viol_cnt <= '0;
        end else if (w_viol && !w_cnt_sat) begin
            r_viol_cnt <= r_viol_cnt + 1'b1;
        end
    end

    assign q         = r_chain[N-1 -: WIDTH];
    assign valid_out = r_vld[STAGES-1];
    assign so        = r_chain[N-1];
    assign viol_cnt  = r_viol_cnt;

endmodule

// File: tb/tb_sedff_pipe_bank.sv
// Randomised and directed checks of sedff_pipe_bank against a stage-array model;
// a second instance with a 2-bit counter exercises saturation on the same stimulus.
module tb_sedff_pipe_bank;

    localparam int W = 8;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst, en, valid_in, clr, set, se, si, notifier;
    logic [W-1:0] d;

    logic [W-1:0] q, q_s;
    logic         valid_out, valid_out_s, so, so_s;
    logic [7:0]   viol_cnt;
    logic [1:0]   viol_cnt_s;

    always #5 clk = ~clk;

    sedff_pipe_bank #(.WIDTH(W), .STAGES(S), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .d(d), .valid_in(valid_in), .clr(clr), .set(set),
        .se(se), .si(si), .notifier(notifier),
        .q(q), .valid_out(valid_out), .so(so), .viol_cnt(viol_cnt)
    );

    sedff_pipe_bank #(.WIDTH(W), .STAGES(S), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .en(en), .d(d), .valid_in(valid_in), .clr(clr), .set(set),
        .se(se), .si(si), .notifier(notifier),
        .q(q_s), .valid_out(valid_out_s), .so(so_s), .viol_cnt(viol_cnt_s)
    );

    logic [W-1:0] m_st [S];
    logic         m_vld [S];
    int           m_cnt, m_cnt_s;
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_idle();
        rst = 0; en = 0; d = '0; valid_in = 0; clr = 0; set = 0; se = 0; si = 0; notifier = 0;
    endtask

    // Reference: stages as an array, scan as a flat bit index k = s*W+b.
    task automatic model_edge();
        logic [W-1:0] old [S];
        int kk;
        for (int s = 0; s < S; s++) old[s] = m_st[s];
        if (rst) begin
            for (int s = 0; s < S; s++) begin m_st[s] = '0; m_vld[s] = 0; end
            m_cnt = 0; m_cnt_s = 0;
        end else begin
            if (notifier || (clr && set)) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt_s < 3) m_cnt_s++;
            end
            if (clr) begin
                for (int s = 0; s < S; s++) begin m_st[s] = '0; m_vld[s] = 0; end
            end else if (set) begin
                for (int s = 0; s < S; s++) begin m_st[s] = '1; m_vld[s] = 1; end
            end else if (se) begin
                for (int k = 0; k < S*W; k++) begin
                    if (k == 0) m_st[0][0] = si;
                    else begin
                        kk = k - 1;
                        m_st[k/W][k%W] = old[kk/W][kk%W];
                    end
                end
            end else if (en) begin
                for (int s = S-1; s > 0; s--) begin m_st[s] = m_st[s-1]; m_vld[s] = m_vld[s-1]; end
                m_st[0] = d; m_vld[0] = valid_in;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk_eq("q", q, m_st[S-1]);
        chk_eq("valid_out", valid_out, m_vld[S-1]);
        chk_eq("so", so, m_st[S-1][W-1]);
        chk_eq("viol_cnt", viol_cnt, m_cnt);
        chk_eq("viol_cnt_sat", viol_cnt_s, m_cnt_s);
    endtask

    task automatic do_reset();
        set_idle(); rst = 1; step(); rst = 0;
    endtask

    task automatic stream(input logic [W-1:0] dv, input logic vv);
        set_idle(); en = 1; d = dv; valid_in = vv; step();
    endtask

    initial begin
        logic [23:0] pat;
        pat = 24'hC35A81;
        for (int s = 0; s < S; s++) begin m_st[s] = 'x; m_vld[s] = 'x; end
        m_cnt = 0; m_cnt_s = 0;

        // reset with random other inputs
        set_idle(); #2;
        rst = 1; en = $urandom; d = $urandom; valid_in = $urandom; clr = $urandom; set = $urandom;
        se = $urandom; si = $urandom; notifier = $urandom;
        step();
        chk_eq("rst_q", q, 0); chk_eq("rst_vo", valid_out, 0);
        chk_eq("rst_so", so, 0); chk_eq("rst_cnt", viol_cnt, 0);

        // latency
        stream(8'hA5, 1); stream(8'h3C, 0); stream(8'h11, 1);
        chk_eq("lat_q3", q, 8'hA5); chk_eq("lat_v3", valid_out, 1);
        stream(8'h22, 1);
        chk_eq("lat_q4", q, 8'h3C); chk_eq("lat_v4", valid_out, 0);

        // latency with a stall on edge 2
        do_reset();
        stream(8'hA5, 1);
        set_idle(); d = 8'hEE; valid_in = 0; step();
        stream(8'h3C, 0); chk_eq("stall_q3", q, 8'h00);
        stream(8'h44, 0); chk_eq("stall_q4", q, 8'hA5); chk_eq("stall_v4", valid_out, 1);

        // clr / set priority and conflict counting
        do_reset();
        set_idle(); set = 1; step();
        chk_eq("set_q", q, 8'hFF); chk_eq("set_v", valid_out, 1);
        set_idle(); set = 1; clr = 1; step();
        chk_eq("conf_q", q, 0); chk_eq("conf_v", valid_out, 0); chk_eq("conf_cnt", viol_cnt, 1);
        set_idle(); set = 1; clr = 1; notifier = 1; step();
        chk_eq("conf_notif_cnt", viol_cnt, 2);

        // scan flush of an all-ones preload
        set_idle(); set = 1; step();
        for (int i = 0; i < 24; i++) begin
            chk_eq("scan_so_pre", so, 1);
            set_idle(); se = 1; si = 0; step();
        end
        chk_eq("scan_flush_q", q, 0); chk_eq("scan_flush_v", valid_out, 1);

        // scan pattern MSB-first
        for (int i = 23; i >= 0; i--) begin
            set_idle(); se = 1; si = pat[i]; step();
        end
        chk_eq("scan_pat_q", q, 8'hC3);

        // saturation on the 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_idle(); notifier = 1; step();
            chk_eq("sat_cnt", viol_cnt_s, (i < 3) ? i + 1 : 3);
        end
        do_reset(); chk_eq("sat_rst", viol_cnt_s, 0);

        // reset mid-scan
        set_idle(); set = 1; step();
        for (int i = 0; i < 10; i++) begin set_idle(); se = 1; si = 1; step(); end
        do_reset();
        chk_eq("midscan_q", q, 0); chk_eq("midscan_so", so, 0); chk_eq("midscan_v", valid_out, 0);

        // reset mid-stream, then clean restart
        stream(8'h5A, 1); stream(8'h6B, 1);
        do_reset(); chk_eq("midstr_q", q, 0); chk_eq("midstr_v", valid_out, 0);
        stream(8'h77, 1); stream(8'h01, 0);
        chk_eq("restart_q2", valid_out, 0);
        stream(8'h02, 0);
        chk_eq("restart_q3", q, 8'h77); chk_eq("restart_v3", valid_out, 1);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            set_idle();
            rst      = ($urandom_range(99) < 2);
            clr      = ($urandom_range(99) < 4);
            set      = ($urandom_range(99) < 4);
            se       = ($urandom_range(99) < 12);
            en       = ($urandom_range(99) < 65);
            notifier = ($urandom_range(99) < 8);
            si       = $urandom;
            d        = $urandom;
            valid_in = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
